// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse / display bundle between the stopwatch controller and its neighbours.
// master drives the debounced pulses; slave is the controller producing the display.
interface stopwatch_ctrl_if;
  logic       START_STOP;
  logic       CLEAR;
  logic       LAP;
  logic [3:0] DISP0;
  logic [3:0] DISP1;
  logic [3:0] DISP2;
  logic [3:0] DISP3;
  logic       RUNNING;
  logic       TICK;
  logic       ROLLOVER;
  logic       LAP_ACTIVE;

  modport master (
    output START_STOP, CLEAR, LAP,
    input  DISP0, DISP1, DISP2, DISP3, RUNNING, TICK, ROLLOVER, LAP_ACTIVE
  );

  modport slave (
    input  START_STOP, CLEAR, LAP,
    output DISP0, DISP1, DISP2, DISP3, RUNNING, TICK, ROLLOVER, LAP_ACTIVE
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/clear FSM, tick prescaler and MM:SS BCD digit chain.
// Optional lap display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned PRESC_W  = 27
) (
  input logic             CLK,
  input logic             RESET,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt;
  logic [DIG_W-1:0]   d0, d1, d2, d3;
  logic [DIG_W-1:0]   d0_nxt, d1_nxt, d2_nxt, d3_nxt;
  logic [DIG_W-1:0]   disp0, disp1, disp2, disp3;
  logic               running;
  logic               tick;
  logic               rollover;
  logic               lap_active;
  logic               lap_nxt;

  logic               run_c;
  logic               clear_c;
  logic               tick_c;
  logic               rollover_c;
  logic               c1, c2, c3;

  // Prescaler, carry ripple and next digit values
  always_comb begin
    run_c      = (state == RUN);
    clear_c    = sw.CLEAR && (state == PAUSED);
    tick_c     = run_c && (presc == PRESC_W'(TICK_DIV - 1));
    c1         = (d0 == DIG_W'(9));
    c2         = c1 && (d1 == DIG_W'(5));
    c3         = c2 && (d2 == DIG_W'(9));
    rollover_c = tick_c && c3 && (d3 == DIG_W'(5));

    presc_nxt = presc;
    d0_nxt    = d0;
    d1_nxt    = d1;
    d2_nxt    = d2;
    d3_nxt    = d3;

    if (clear_c) begin
      presc_nxt = '0;
      d0_nxt    = '0;
      d1_nxt    = '0;
      d2_nxt    = '0;
      d3_nxt    = '0;
    end else if (tick_c) begin
      presc_nxt = '0;
      d0_nxt    = c1 ? '0 : d0 + DIG_W'(1);
      if (c1) d1_nxt = (d1 == DIG_W'(5)) ? '0 : d1 + DIG_W'(1);
      if (c2) d2_nxt = (d2 == DIG_W'(9)) ? '0 : d2 + DIG_W'(1);
      if (c3) d3_nxt = (d3 == DIG_W'(5)) ? '0 : d3 + DIG_W'(1);
    end else if (run_c) begin
      presc_nxt = presc + PRESC_W'(1);
    end
  end

`ifdef STOPWATCH_LAP_EN
  // LAP toggles the freeze only while running; elsewhere LAP or CLEAR releases it
  always_comb begin
    lap_nxt = lap_active;
    if (run_c) begin
      lap_nxt = lap_active ^ sw.LAP;
    end else if (sw.LAP || sw.CLEAR) begin
      lap_nxt = 1'b0;
    end
  end
`else
  logic lap_unused;
  assign lap_unused = sw.LAP;
  assign lap_nxt    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      running    <= 1'b0;
      presc      <= '0;
      d0         <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      disp0      <= '0;
      disp1      <= '0;
      disp2      <= '0;
      disp3      <= '0;
      tick       <= 1'b0;
      rollover   <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      // CLEAR beats START_STOP outside RUN; inside RUN only START_STOP matters
      case (state)
        IDLE: begin
          if (!sw.CLEAR && sw.START_STOP) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (sw.START_STOP) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (sw.CLEAR) begin
            state   <= IDLE;
          end else if (sw.START_STOP) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      presc      <= presc_nxt;
      d0         <= d0_nxt;
      d1         <= d1_nxt;
      d2         <= d2_nxt;
      d3         <= d3_nxt;
      tick       <= tick_c;
      rollover   <= rollover_c;
      lap_active <= lap_nxt;

      // While frozen the display simply keeps what it was last showing
      if (!lap_nxt) begin
        disp0 <= d0_nxt;
        disp1 <= d1_nxt;
        disp2 <= d2_nxt;
        disp3 <= d3_nxt;
      end
    end
  end

  assign sw.DISP0      = disp0;
  assign sw.DISP1      = disp1;
  assign sw.DISP2      = disp2;
  assign sw.DISP3      = disp3;
  assign sw.RUNNING    = running;
  assign sw.TICK       = tick;
  assign sw.ROLLOVER   = rollover;
  assign sw.LAP_ACTIVE = lap_active;

endmodule
